// File: rtl/fir_pkg.sv
// Shared types, widths and output rounding for the FIR tap sequencer.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping.
package fir_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 7;
    localparam int unsigned ACCW = 40;
    localparam int unsigned PW   = 2 * DW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Round half up, arithmetic shift, then reduce to DW bits (saturate or wrap).
    function automatic logic [DW-1:0] round_out(input logic signed [ACCW-1:0] acc,
                                                input int unsigned shift);
        logic signed [ACCW:0] sum;
        logic signed [ACCW:0] shd;
`ifdef FIR_SAT_EN
        logic hi_ones;
        logic hi_zeros;
`endif
        sum = {acc[ACCW-1], acc};
        if (shift != 0) begin
            sum = sum + ((ACCW+1)'(1) << (shift - 1));
        end
        shd = sum >>> shift;
`ifdef FIR_SAT_EN
        hi_ones  = &shd[ACCW:DW-1];
        hi_zeros = ~|shd[ACCW:DW-1];
        if (!hi_ones && !hi_zeros) begin
            round_out = shd[ACCW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            round_out = shd[DW-1:0];
        end
`else
        round_out = DW'(shd);
`endif
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiplier feeding a 40-bit accumulator with clear and enable.
module fir_mac
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [PW-1:0]   prod_q;
    logic                   pv_q;
    logic signed [ACCW-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            pv_q <= en_i;
            if (en_i) begin
                prod_q <= a_i * b_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (pv_q) begin
                acc_q <= acc_q + ACCW'(prod_q);
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sample intake, decimation phase and tap sweep for the 128x16 delay line.
// Output reduction follows FIR_SAT_EN (saturate) or wraps when undefined.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS  = 128,
    parameter int unsigned DEC    = 1,
    parameter int unsigned OSHIFT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          in_rdy,
    output logic [DW-1:0] srl_d,
    output logic          srl_ce,
    output logic [AW-1:0] srl_a,
    input  logic [DW-1:0] srl_y,
    output logic [AW-1:0] coef_a,
    input  logic [DW-1:0] coef_q,
    output logic          out_vld,
    output logic [DW-1:0] out_dat
);

    localparam int unsigned    PHW      = 5;
    localparam logic [AW-1:0]  LAST_TAP = AW'(NTAPS - 1);
    localparam logic [PHW-1:0] DEC_CNT  = PHW'(DEC);

    state_e                 state_q, state_d;
    logic [PHW-1:0]         phase_q, phase_d;
    logic [1:0]             drain_q, drain_d;
    logic                   in_rdy_q, in_rdy_d;
    logic [DW-1:0]          srl_d_q, srl_d_d;
    logic                   srl_ce_q, srl_ce_d;
    logic [AW-1:0]          srl_a_q, srl_a_d;
    logic [AW-1:0]          coef_a_q;
    logic                   out_vld_q, out_vld_d;
    logic [DW-1:0]          out_dat_q, out_dat_d;
    logic [AW-1:0]          tap_d;
    logic                   accept_c;
    logic                   acc_clr_c;
    logic [DW-1:0]          y_q;
    logic                   yv_q;
    logic signed [ACCW-1:0] acc_w;

    // Next state; every output register is loaded from the state being entered.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        drain_d   = drain_q;
        tap_d     = '0;
        acc_clr_c = 1'b0;
        accept_c  = in_vld & in_rdy_q;

        case (state_q)
            IDLE: begin
                if (accept_c) state_d = LOAD;
            end
            LOAD: begin
                if (phase_q + PHW'(1) == DEC_CNT) begin
                    phase_d   = '0;
                    acc_clr_c = 1'b1;
                    state_d   = RUN;
                end else begin
                    phase_d = phase_q + PHW'(1);
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (srl_a_q == LAST_TAP) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    tap_d = srl_a_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'd2) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_d = accept_c ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_rdy_d  = (state_d == IDLE) || (state_d == DONE);
        srl_ce_d  = (state_d == LOAD);
        srl_a_d   = (state_d == RUN) ? tap_d : '0;
        srl_d_d   = accept_c ? in_dat : srl_d_q;
        out_vld_d = (state_d == DONE);
        out_dat_d = (state_d == DONE) ? round_out(acc_w, OSHIFT) : out_dat_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            drain_q   <= '0;
            in_rdy_q  <= 1'b1;
            srl_d_q   <= '0;
            srl_ce_q  <= 1'b0;
            srl_a_q   <= '0;
            coef_a_q  <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            y_q       <= '0;
            yv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            drain_q   <= drain_d;
            in_rdy_q  <= in_rdy_d;
            srl_d_q   <= srl_d_d;
            srl_ce_q  <= srl_ce_d;
            srl_a_q   <= srl_a_d;
            coef_a_q  <= srl_a_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            // Delay-line data is retimed to line up with the synchronous ROM output.
            y_q       <= srl_y;
            yv_q      <= (state_q == RUN);
        end
    end

    fir_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (acc_clr_c),
        .en_i  (yv_q),
        .a_i   (y_q),
        .b_i   (coef_q),
        .acc_o (acc_w)
    );

    assign in_rdy  = in_rdy_q;
    assign srl_d   = srl_d_q;
    assign srl_ce  = srl_ce_q;
    assign srl_a   = srl_a_q;
    assign coef_a  = coef_a_q;
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: two instances (4 taps/DEC 1, 128 taps/DEC 2) against a arithmetic reference model.
module tb_fir_tap_sequencer;

    localparam int unsigned OSH  = 15;
    localparam int unsigned NT0  = 4;
    localparam int unsigned DEC0 = 1;
    localparam int unsigned NT1  = 128;
    localparam int unsigned DEC1 = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        vld  [2];
    logic [15:0] dat  [2];
    logic        rdy  [2];
    logic [15:0] sd   [2];
    logic        ce   [2];
    logic [6:0]  sa   [2];
    logic [15:0] y    [2];
    logic [6:0]  ca   [2];
    logic [15:0] cq   [2];
    logic        ov   [2];
    logic [15:0] od   [2];

    fir_tap_sequencer #(.NTAPS(NT0), .DEC(DEC0), .OSHIFT(OSH)) u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .in_vld(vld[0]), .in_dat(dat[0]), .in_rdy(rdy[0]),
        .srl_d(sd[0]), .srl_ce(ce[0]), .srl_a(sa[0]), .srl_y(y[0]),
        .coef_a(ca[0]), .coef_q(cq[0]), .out_vld(ov[0]), .out_dat(od[0])
    );

    fir_tap_sequencer #(.NTAPS(NT1), .DEC(DEC1), .OSHIFT(OSH)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .in_vld(vld[1]), .in_dat(dat[1]), .in_rdy(rdy[1]),
        .srl_d(sd[1]), .srl_ce(ce[1]), .srl_a(sa[1]), .srl_y(y[1]),
        .coef_a(ca[1]), .coef_q(cq[1]), .out_vld(ov[1]), .out_dat(od[1])
    );

    // External delay line (no reset) and synchronous coefficient ROM per instance.
    logic [15:0]        line [2][128];
    logic signed [15:0] rom  [2][128];
    logic               tb_clr;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tb_clr) begin
                for (int k = 0; k < 128; k++) line[d][k] <= '0;
            end else if (ce[d]) begin
                for (int k = 127; k > 0; k--) line[d][k] <= line[d][k-1];
                line[d][0] <= sd[d];
            end
            cq[d] <= rom[d][ca[d]];
        end
    end

    assign y[0] = line[0][sa[0]];
    assign y[1] = line[1][sa[1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int ntaps(input int d);
        return (d == 0) ? int'(NT0) : int'(NT1);
    endfunction

    function automatic int decim(input int d);
        return (d == 0) ? int'(DEC0) : int'(DEC1);
    endfunction

    // Reference model state: sample history (newest first) and expected handshake timing.
    int          hist       [2][128];
    int          phase      [2];
    int          busy_until [2];
    int          run_s      [2];
    int          pend_cyc   [2];
    int          vcount     [2];
    int          cecount    [2];
    bit          run_on     [2];
    bit          pend       [2];
    bit          acc_prev   [2];
    bit          seen_rst   [2];
    logic [15:0] pend_val   [2];
    logic [15:0] last_out   [2];
    logic [15:0] prev_dat   [2];
    logic [15:0] log0 [$];

    function automatic logic [15:0] ref_out(input int d);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < ntaps(d); k++) begin
            acc += longint'(hist[d][k]) * longint'($signed(rom[d][k]));
        end
        r = (acc + (longint'(1) <<< (OSH - 1))) >>> OSH;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return 16'(r);
    endfunction

    always @(negedge clk) begin
        int  ea;
        bit  exp_v;
        for (int d = 0; d < 2; d++) begin
            if (seen_rst[d]) begin
                check($sformatf("in_rdy[%0d]", d), 32'(rdy[d]), 32'(cyc > busy_until[d]));
                check($sformatf("srl_ce[%0d]", d), 32'(ce[d]), 32'(acc_prev[d]));
                if (acc_prev[d]) check($sformatf("srl_d[%0d]", d), 32'(sd[d]), 32'(prev_dat[d]));
                ea = (run_on[d] && cyc >= run_s[d] && cyc < run_s[d] + ntaps(d)) ? cyc - run_s[d] : 0;
                check($sformatf("srl_a[%0d]", d), 32'(sa[d]), 32'(ea));
                check($sformatf("coef_a[%0d]", d), 32'(ca[d]), 32'(ea));
                exp_v = pend[d] && (cyc == pend_cyc[d]);
                check($sformatf("out_vld[%0d]", d), 32'(ov[d]), 32'(exp_v));
                if (ov[d] === 1'b1) vcount[d]++;
                if (ce[d] === 1'b1) cecount[d]++;
                if (exp_v) begin
                    last_out[d] = pend_val[d];
                    pend[d]     = 1'b0;
                    if (d == 0) log0.push_back(od[d]);
                end
                check($sformatf("out_dat[%0d]", d), 32'(od[d]), 32'(last_out[d]));
            end
            acc_prev[d] = 1'b0;
            if (rstn[d] !== 1'b1) begin
                seen_rst[d]   = 1'b1;
                phase[d]      = 0;
                pend[d]       = 1'b0;
                busy_until[d] = cyc;
                run_on[d]     = 1'b0;
                last_out[d]   = '0;
            end else if (vld[d] === 1'b1 && rdy[d] === 1'b1) begin
                for (int k = 127; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0]  = int'($signed(dat[d]));
                acc_prev[d] = 1'b1;
                prev_dat[d] = dat[d];
                phase[d]++;
                if (phase[d] == decim(d)) begin
                    phase[d]      = 0;
                    pend[d]       = 1'b1;
                    pend_val[d]   = ref_out(d);
                    pend_cyc[d]   = cyc + ntaps(d) + 5;
                    busy_until[d] = cyc + ntaps(d) + 4;
                    run_on[d]     = 1'b1;
                    run_s[d]      = cyc + 2;
                end else begin
                    busy_until[d] = cyc + 1;
                end
            end
        end
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic send(input int d, input logic [15:0] v, input int gap);
        int n;
        bit got;
        repeat (gap) begin @(posedge clk); #1; end
        vld[d] = 1'b1;
        dat[d] = v;
        got = 1'b0;
        n = 0;
        while (!got && n < 1000) begin
            @(negedge clk);
            got = (rdy[d] === 1'b1);
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("send_accept[%0d]", d), 32'(got), 32'd1);
        vld[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((pend[d] || rdy[d] !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_reached[%0d]", d), 32'(n < 2000), 32'd1);
        @(posedge clk); #1;
    endtask

    int          imp_exp [8] = '{500, 1000, 1500, 2000, 0, 0, 0, 0};
    logic [15:0] sat_exp;
    int          v0;
    int          c0;

    initial begin
        tb_clr  = 1'b1;
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        vld[0]  = 1'b0; vld[1]  = 1'b0;
        dat[0]  = '0;   dat[1]  = '0;
        for (int k = 0; k < 128; k++) begin
            rom[0][k] = (k < 4) ? 16'(1000 * (k + 1)) : 16'sd0;
            rom[1][k] = 16'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1; tb_clr = 1'b0;

        @(negedge clk);
        check("rst_in_rdy", 32'(rdy[0]), 32'd1);
        check("rst_out_dat", 32'(od[1]), 32'd0);
        check("rst_srl_d", 32'(sd[0]), 32'd0);
        @(posedge clk); #1;

        // Impulse response on the 4-tap instance.
        log0.delete();
        send(0, 16'd16384, 0);
        for (int i = 0; i < 7; i++) send(0, 16'd0, int'($urandom_range(0, 2)));
        wait_idle(0);
        check("imp_count", 32'(log0.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log0.size()) check($sformatf("imp%0d", i), 32'(log0[i]), 32'(16'(imp_exp[i])));
        end

        // Full-scale saturation / wrap.
        for (int k = 0; k < 4; k++) rom[0][k] = 16'sd32767;
        log0.delete();
        for (int i = 0; i < 4; i++) send(0, 16'd32767, 1);
        wait_idle(0);
`ifdef FIR_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'hFFF8;
`endif
        check("sat_count", 32'(log0.size()), 32'd4);
        if (log0.size() >= 4) check("sat_out4", 32'(log0[3]), 32'(sat_exp));

        // Random coefficients and samples on the 4-tap instance.
        for (int k = 0; k < 4; k++) rom[0][k] = 16'($urandom);
        for (int i = 0; i < 24; i++) send(0, 16'($urandom), int'($urandom_range(0, 3)));
        wait_idle(0);

        // Decimation by 2 on the 128-tap instance.
        v0 = vcount[1];
        for (int i = 0; i < 8; i++) send(1, 16'($urandom), int'($urandom_range(0, 3)));
        wait_idle(1);
        check("dec_pulses", 32'(vcount[1] - v0), 32'd4);

        // Valid held high continuously.
        v0 = vcount[1];
        c0 = cecount[1];
        for (int i = 0; i < 10; i++) send(1, 16'($urandom), 0);
        wait_idle(1);
        check("bp_pulses", 32'(vcount[1] - v0), 32'd5);
        check("bp_ce_pulses", 32'(cecount[1] - c0), 32'd10);

        // Reset pulse while tap 50 is issued.
        v0 = vcount[1];
        send(1, 16'($urandom), 0);
        send(1, 16'($urandom), 0);
        while (cyc < run_s[1] + 50) begin @(posedge clk); #1; end
        rstn[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        @(negedge clk);
        check("mid_rst_vld", 32'(ov[1]), 32'd0);
        check("mid_rst_ce", 32'(ce[1]), 32'd0);
        check("mid_rst_srl_a", 32'(sa[1]), 32'd0);
        check("mid_rst_coef_a", 32'(ca[1]), 32'd0);
        check("mid_rst_rdy", 32'(rdy[1]), 32'd1);
        check("mid_rst_out_dat", 32'(od[1]), 32'd0);
        check("mid_rst_srl_d", 32'(sd[1]), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        check("mid_rst_no_vld", 32'(vcount[1] - v0), 32'd0);

        v0 = vcount[1];
        for (int i = 0; i < 6; i++) send(1, 16'($urandom), int'($urandom_range(0, 2)));
        wait_idle(1);
        check("post_rst_pulses", 32'(vcount[1] - v0), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, fails);
        $fatal(1);
    end

endmodule
